turn_sequencer: RTL

Game-flow initiator that drives the two `player_controller` instances behind the VGA layer mux. It samples a roll button, draws a 1..6 dice value, and computes each player's clamped target X. It then issues the `move_start`/`target_x` command to the active player, waits for that player's `turn_done`, and alternates turns until a player reaches the flag.

---
 rtl/game_pkg.sv | 27 ++
 rtl/dice_counter.sv | 38 +++
 rtl/turn_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, board constants and target helper for the turn game
package game_pkg;

  typedef logic player_id_t;

  typedef enum logic [2:0] {
    IDLE,
    ROLL,
    ISSUE,
    WAIT,
    CHECK,
    WIN
  } turn_state_t;

  localparam int START_X = 20;
  localparam int FLAG_X  = 620;
  localparam int STEP_PX = 40;

  // Advance a position by dice pips, saturating at the flag column.
  function automatic logic [9:0] calc_target(input logic [9:0] pos, input logic [2:0] dice,
                                             input int step, input int flag);
    logic [10:0] sum;
    sum = {1'b0, pos} + 11'(dice) * 11'(step);
    return (sum >= 11'(flag)) ? 10'(flag) : sum[9:0];
  endfunction

endpackage

// File: rtl/dice_counter.sv
// rtl/dice_counter.sv - free-running 1..6 counter with a latched dice output
module dice_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       latch_en,
  output logic [2:0] cnt,
  output logic [2:0] dice_value
);

  logic [2:0] cnt_q, cnt_d;
  logic [2:0] dice_q, dice_d;

  // Count 1..6 every clock; latch the current face on request; clr acts like reset.
  always_comb begin
    cnt_d  = (cnt_q == 3'd6) ? 3'd1 : cnt_q + 3'd1;
    dice_d = latch_en ? cnt_q : dice_q;
    if (clr) begin
      cnt_d  = 3'd1;
      dice_d = 3'd0;
    end
  end

  // Counter and latched-face registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 3'd1;
      dice_q <= 3'd0;
    end else begin
      cnt_q  <= cnt_d;
      dice_q <= dice_d;
    end
  end

  assign cnt        = cnt_q;
  assign dice_value = dice_q;

endmodule

// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - two-player roll/move/turn FSM; TURN_TIMEOUT_EN adds a WAIT watchdog
module turn_sequencer import game_pkg::*; #(
  parameter int START_X        = game_pkg::START_X,
  parameter int FLAG_X         = game_pkg::FLAG_X,
  parameter int STEP_PX        = game_pkg::STEP_PX,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_btn,
  input  logic       new_game,
  output logic       move_start_p1,
  output logic [9:0] target_x_p1,
  input  logic       turn_done_p1,
  output logic       move_start_p2,
  output logic [9:0] target_x_p2,
  input  logic       turn_done_p2,
  output logic       active_player,
  output logic [2:0] dice_value,
  output logic       busy,
  output logic       winner_valid,
  output logic       winner_id
);

  turn_state_t state_q, state_d;
  player_id_t  active_q, active_d;
  player_id_t  winner_id_q, winner_id_d;
  logic        move_start_p1_q, move_start_p1_d;
  logic        move_start_p2_q, move_start_p2_d;
  logic [9:0]  target_x_p1_q, target_x_p1_d;
  logic [9:0]  target_x_p2_q, target_x_p2_d;
  logic [9:0]  pos_p1_q, pos_p1_d;
  logic [9:0]  pos_p2_q, pos_p2_d;
  logic        busy_q, busy_d;
  logic        winner_valid_q, winner_valid_d;
  logic        roll_prev_q, roll_prev_d;
  logic        done_p1_prev_q, done_p1_prev_d;
  logic        done_p2_prev_q, done_p2_prev_d;

  logic [2:0]  dice_cnt;
  logic        dice_latch, dice_clr;
  logic        roll_edge, done_edge, timeout_hit;
  logic [9:0]  active_pos, roll_target;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  dice_counter u_dice (
    .clk        (clk),
    .rst        (reset),
    .clr        (dice_clr),
    .latch_en   (dice_latch),
    .cnt        (dice_cnt),
    .dice_value (dice_value)
  );

`ifdef TURN_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;

  // Watchdog counts WAIT cycles from zero and fires on the last allowed cycle.
  always_comb begin
    to_cnt_d    = (state_q == WAIT) ? to_cnt_q + 32'd1 : 32'd0;
    timeout_hit = (state_q == WAIT) && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt_q <= 32'd0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output decode for the turn FSM.
  always_comb begin
    state_d         = state_q;
    active_d        = active_q;
    winner_id_d     = winner_id_q;
    move_start_p1_d = 1'b0;
    move_start_p2_d = 1'b0;
    target_x_p1_d   = target_x_p1_q;
    target_x_p2_d   = target_x_p2_q;
    pos_p1_d        = pos_p1_q;
    pos_p2_d        = pos_p2_q;
    dice_latch      = 1'b0;
    dice_clr        = 1'b0;
    roll_prev_d     = roll_btn;
    done_p1_prev_d  = turn_done_p1;
    done_p2_prev_d  = turn_done_p2;
    roll_edge       = roll_btn & ~roll_prev_q;
    done_edge       = active_q ? (turn_done_p2 & ~done_p2_prev_q)
                               : (turn_done_p1 & ~done_p1_prev_q);
    active_pos      = active_q ? pos_p2_q : pos_p1_q;
    roll_target     = calc_target(active_pos, dice_cnt, STEP_PX, FLAG_X);

    case (state_q)
      IDLE: if (roll_edge) state_d = ROLL;
      ROLL: begin
        // Target and move_start are registered here so both appear in ISSUE.
        dice_latch = 1'b1;
        if (active_q) begin
          target_x_p2_d   = roll_target;
          move_start_p2_d = 1'b1;
        end else begin
          target_x_p1_d   = roll_target;
          move_start_p1_d = 1'b1;
        end
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done_edge || timeout_hit) begin
          if (active_q) pos_p2_d = target_x_p2_q;
          else          pos_p1_d = target_x_p1_q;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (active_pos == 10'(FLAG_X)) begin
          winner_id_d = active_q;
          state_d     = WIN;
        end else begin
          active_d = ~active_q;
          state_d  = IDLE;
        end
      end
      WIN: begin
        if (new_game) begin
          active_d      = 1'b0;
          winner_id_d   = 1'b0;
          target_x_p1_d = 10'(START_X);
          target_x_p2_d = 10'(START_X);
          pos_p1_d      = 10'(START_X);
          pos_p2_d      = 10'(START_X);
          dice_clr      = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d         = (state_d == ROLL) || (state_d == ISSUE) ||
                     (state_d == WAIT) || (state_d == CHECK);
    winner_valid_d = (state_d == WIN);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      active_q        <= 1'b0;
      winner_id_q     <= 1'b0;
      move_start_p1_q <= 1'b0;
      move_start_p2_q <= 1'b0;
      target_x_p1_q   <= 10'(START_X);
      target_x_p2_q   <= 10'(START_X);
      pos_p1_q        <= 10'(START_X);
      pos_p2_q        <= 10'(START_X);
      busy_q          <= 1'b0;
      winner_valid_q  <= 1'b0;
      roll_prev_q     <= 1'b0;
      done_p1_prev_q  <= 1'b0;
      done_p2_prev_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      winner_id_q     <= winner_id_d;
      move_start_p1_q <= move_start_p1_d;
      move_start_p2_q <= move_start_p2_d;
      target_x_p1_q   <= target_x_p1_d;
      target_x_p2_q   <= target_x_p2_d;
      pos_p1_q        <= pos_p1_d;
      pos_p2_q        <= pos_p2_d;
      busy_q          <= busy_d;
      winner_valid_q  <= winner_valid_d;
      roll_prev_q     <= roll_prev_d;
      done_p1_prev_q  <= done_p1_prev_d;
      done_p2_prev_q  <= done_p2_prev_d;
    end
  end

  assign move_start_p1 = move_start_p1_q;
  assign move_start_p2 = move_start_p2_q;
  assign target_x_p1   = target_x_p1_q;
  assign target_x_p2   = target_x_p2_q;
  assign active_player = active_q;
  assign busy          = busy_q;
  assign winner_valid  = winner_valid_q;
  assign winner_id     = winner_id_q;

endmodule
